// File: rtl/friscv_load_pkg.sv
// Shared types for the load writeback path: funct3 codes, error causes and the
// queue entry that remembers where a load's data has to go.
package friscv_load_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_BUS      = 2'b01,
        ERR_MISALIGN = 2'b10,
        ERR_FUNCT3   = 2'b11
    } err_cause_t;

    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] funct3;
        logic [1:0] off;
    } load_entry_t;

    localparam int ENTRY_W = $bits(load_entry_t);

    // Illegal funct3 outranks misalignment, which outranks a bus error.
    function automatic err_cause_t load_check(input logic [2:0] funct3,
                                              input logic [1:0] off,
                                              input logic [1:0] rresp);
        case (funct3)
            LB, LBU: return (rresp != 2'b00) ? ERR_BUS : ERR_NONE;
            LH, LHU: begin
                if (off[0])
                    return ERR_MISALIGN;
                return (rresp != 2'b00) ? ERR_BUS : ERR_NONE;
            end
            LW: begin
                if (off != 2'b00)
                    return ERR_MISALIGN;
                return (rresp != 2'b00) ? ERR_BUS : ERR_NONE;
            end
            default: return ERR_FUNCT3;
        endcase
    endfunction

endpackage

// File: rtl/friscv_load_writeback_if.sv
// Request, read-data and register-write signals of the load writeback unit.
interface friscv_load_writeback_if #(
    parameter int XLEN = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        req_rd_addr;
    logic [2:0]        req_funct3;
    logic [1:0]        req_offset;
    logic              rdata_valid;
    logic              rdata_ready;
    logic [XLEN-1:0]   rdata;
    logic [1:0]        rresp;
    logic              rd_wr;
    logic [4:0]        rd_addr;
    logic [XLEN-1:0]   rd_val;
    logic [XLEN/8-1:0] rd_strb;
    logic [31:0]       pending;
    logic              err_valid;
    logic [1:0]        err_cause;

    modport master (
        output req_valid, req_rd_addr, req_funct3, req_offset,
        output rdata_valid, rdata, rresp,
        input  req_ready, rdata_ready,
        input  rd_wr, rd_addr, rd_val, rd_strb, pending, err_valid, err_cause
    );

    modport slave (
        input  req_valid, req_rd_addr, req_funct3, req_offset,
        input  rdata_valid, rdata, rresp,
        output req_ready, rdata_ready,
        output rd_wr, rd_addr, rd_val, rd_strb, pending, err_valid, err_cause
    );

endinterface

// File: rtl/friscv_scfifo.sv
// Single-clock FIFO; a pop frees its slot in the same cycle so a full FIFO can
// take a push together with a pop.
module friscv_scfifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
)(
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign data_out = mem[rd_ptr[AW-1:0]];

    // Pointers carry one extra wrap bit to tell full from empty.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= data_in;
    end

endmodule

// File: rtl/friscv_load_writeback.sv
// Pairs queued load requests with read-data beats in order, aligns/extends the
// data and drives one registered rd write (or error pulse) per load.
module friscv_load_writeback
    import friscv_load_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
)(
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    srst,
    friscv_load_writeback_if.slave  bus
);

    load_entry_t       push_entry;
    load_entry_t       head;
    logic [ENTRY_W-1:0] head_bits;
    logic              fifo_full;
    logic              fifo_empty;
    logic              req_fire;
    logic              beat_fire;

    logic [31:0]       pending_q;
    logic [31:0]       set_mask;
    logic [31:0]       clr_mask;

    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [XLEN-1:0]   ext_val;
    err_cause_t        cause;

    logic              rd_wr_q;
    logic [4:0]        rd_addr_q;
    logic [XLEN-1:0]   rd_val_q;
    logic [XLEN/8-1:0] rd_strb_q;
    logic              err_valid_q;
    err_cause_t        err_cause_q;

    // A pending destination blocks a new request, so the queue never holds a WAW pair.
    assign bus.req_ready   = !fifo_full &&
                             !(bus.req_rd_addr != 5'd0 && pending_q[bus.req_rd_addr]);
    assign bus.rdata_ready = !fifo_empty;
    assign req_fire        = bus.req_valid && bus.req_ready;
    assign beat_fire       = bus.rdata_valid && bus.rdata_ready;

    assign push_entry.rd     = bus.req_rd_addr;
    assign push_entry.funct3 = bus.req_funct3;
    assign push_entry.off    = bus.req_offset;
    assign head              = load_entry_t'(head_bits);

    friscv_scfifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .srst     (srst),
        .push     (req_fire),
        .data_in  (push_entry),
        .pop      (beat_fire),
        .data_out (head_bits),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        byte_sel = bus.rdata[{head.off, 3'b000} +: 8];
        half_sel = bus.rdata[{head.off[1], 4'b0000} +: 16];
        ext_val  = bus.rdata;
        case (head.funct3)
            LB:      ext_val = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LH:      ext_val = {{(XLEN-16){half_sel[15]}}, half_sel};
            LBU:     ext_val = {{(XLEN-8){1'b0}}, byte_sel};
            LHU:     ext_val = {{(XLEN-16){1'b0}}, half_sel};
            default: ext_val = bus.rdata;
        endcase
        cause = load_check(head.funct3, head.off, bus.rresp);
    end

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (req_fire && bus.req_rd_addr != 5'd0)
            set_mask[bus.req_rd_addr] = 1'b1;
        if (beat_fire && head.rd != 5'd0)
            clr_mask[head.rd] = 1'b1;
    end

    // Clearing on the beat edge makes the bit drop in the cycle the write shows up.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            pending_q <= '0;
        else if (srst)
            pending_q <= '0;
        else
            pending_q <= ((pending_q & ~clr_mask) | set_mask) & ~32'd1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_wr_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_val_q    <= '0;
            rd_strb_q   <= '0;
            err_valid_q <= 1'b0;
            err_cause_q <= ERR_NONE;
        end else if (srst) begin
            rd_wr_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_val_q    <= '0;
            rd_strb_q   <= '0;
            err_valid_q <= 1'b0;
            err_cause_q <= ERR_NONE;
        end else begin
            rd_wr_q     <= beat_fire && cause == ERR_NONE && head.rd != 5'd0;
            rd_strb_q   <= (beat_fire && cause == ERR_NONE && head.rd != 5'd0) ? '1 : '0;
            err_valid_q <= beat_fire && cause != ERR_NONE;
            if (beat_fire) begin
                rd_addr_q   <= head.rd;
                rd_val_q    <= ext_val;
                err_cause_q <= cause;
            end
        end
    end

    assign bus.rd_wr     = rd_wr_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.rd_val    = rd_val_q;
    assign bus.rd_strb   = rd_strb_q;
    assign bus.pending   = pending_q;
    assign bus.err_valid = err_valid_q;
    assign bus.err_cause = err_cause_q;

endmodule

// File: tb/tb_friscv_load_writeback.sv
// Directed and random loads checked cycle by cycle against a queue-based model.
module tb_friscv_load_writeback;

    localparam int DEPTH = 4;

    logic aclk;
    logic aresetn;
    logic srst;

    friscv_load_writeback_if #(.XLEN(32)) bus ();

    friscv_load_writeback #(
        .XLEN  (32),
        .DEPTH (DEPTH)
    ) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .srst    (srst),
        .bus     (bus.slave)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        int rd;
        int f3;
        int off;
    } mentry_t;

    mentry_t     q[$];
    bit [31:0]   m_pend;
    bit          exp_wr;
    bit          exp_err;
    int          exp_addr;
    bit [31:0]   exp_val;
    int          exp_cause;
    int          total;
    int          bad;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference behaviour of one retired load, derived from the load rules directly.
    task automatic modelLoad(input mentry_t e, input bit [31:0] data, input int resp);
        bit [31:0] b;
        bit [31:0] h;
        int        cause;
        b = (data >> (8 * e.off)) & 32'hFF;
        h = (data >> (16 * (e.off / 2))) & 32'hFFFF;
        if (!(e.f3 inside {0, 1, 2, 4, 5}))
            cause = 3;
        else if (((e.f3 == 1 || e.f3 == 5) && (e.off % 2) != 0) || (e.f3 == 2 && e.off != 0))
            cause = 2;
        else if (resp != 0)
            cause = 1;
        else
            cause = 0;
        case (e.f3)
            0:       exp_val = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            1:       exp_val = (h >= 32768) ? h + 32'hFFFF_0000 : h;
            4:       exp_val = b;
            5:       exp_val = h;
            default: exp_val = data;
        endcase
        if (cause != 0) begin
            exp_err   = 1'b1;
            exp_cause = cause;
        end else if (e.rd != 0) begin
            exp_wr   = 1'b1;
            exp_addr = e.rd;
        end
        if (e.rd != 0)
            m_pend[e.rd] = 1'b0;
    endtask

    task automatic applyStimulus(input bit rv, input int rd, input int f3, input int off,
                                 input bit bv, input bit [31:0] data, input int resp,
                                 input bit sr);
        bit      er;
        bit      eb;
        mentry_t e;
        @(negedge aclk);
        bus.req_valid   = rv;
        bus.req_rd_addr = 5'(rd);
        bus.req_funct3  = 3'(f3);
        bus.req_offset  = 2'(off);
        bus.rdata_valid = bv;
        bus.rdata       = data;
        bus.rresp       = 2'(resp);
        srst            = sr;
        #1;
        er = (q.size() < DEPTH) && !(rd != 0 && m_pend[rd]);
        eb = (q.size() != 0);
        checkOutput("req_ready", {31'd0, bus.req_ready}, {31'd0, er});
        checkOutput("rdata_ready", {31'd0, bus.rdata_ready}, {31'd0, eb});
        @(posedge aclk);
        exp_wr  = 1'b0;
        exp_err = 1'b0;
        if (sr) begin
            q.delete();
            m_pend = '0;
        end else begin
            if (bv && eb) begin
                e = q.pop_front();
                modelLoad(e, data, resp);
            end
            if (rv && er) begin
                q.push_back('{rd: rd, f3: f3, off: off});
                if (rd != 0)
                    m_pend[rd] = 1'b1;
            end
        end
        #1;
        checkOutput("rd_wr", {31'd0, bus.rd_wr}, {31'd0, exp_wr});
        checkOutput("err_valid", {31'd0, bus.err_valid}, {31'd0, exp_err});
        checkOutput("pending", bus.pending, m_pend);
        if (exp_wr) begin
            checkOutput("rd_addr", {27'd0, bus.rd_addr}, 32'(exp_addr));
            checkOutput("rd_val", bus.rd_val, exp_val);
            checkOutput("rd_strb", {28'd0, bus.rd_strb}, 32'hF);
        end
        if (exp_err)
            checkOutput("err_cause", {30'd0, bus.err_cause}, 32'(exp_cause));
        if (sr) begin
            checkOutput("srst_rd_addr", {27'd0, bus.rd_addr}, 32'd0);
            checkOutput("srst_rd_val", bus.rd_val, 32'd0);
            checkOutput("srst_rd_strb", {28'd0, bus.rd_strb}, 32'd0);
            checkOutput("srst_err_cause", {30'd0, bus.err_cause}, 32'd0);
        end
    endtask

    task automatic idleBeat(input bit [31:0] data, input int resp);
        applyStimulus(1'b0, 0, 0, 0, 1'b1, data, resp, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && q.size() > 0; i++)
            idleBeat($urandom, 0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_pending"}, bus.pending, 32'd0);
        checkOutput({tag, "_rdata_ready"}, {31'd0, bus.rdata_ready}, 32'd0);
        checkOutput({tag, "_rd_wr"}, {31'd0, bus.rd_wr}, 32'd0);
        checkOutput({tag, "_rd_addr"}, {27'd0, bus.rd_addr}, 32'd0);
        checkOutput({tag, "_rd_val"}, bus.rd_val, 32'd0);
        checkOutput({tag, "_rd_strb"}, {28'd0, bus.rd_strb}, 32'd0);
        checkOutput({tag, "_err_valid"}, {31'd0, bus.err_valid}, 32'd0);
        checkOutput({tag, "_err_cause"}, {30'd0, bus.err_cause}, 32'd0);
    endtask

    task automatic asyncResetPulse();
        @(negedge aclk);
        bus.req_valid   = 1'b0;
        bus.rdata_valid = 1'b0;
        #1;
        aresetn = 1'b0;
        #1;
        q.delete();
        m_pend = '0;
        checkResetState("areset");
        #1;
        aresetn = 1'b1;
    endtask

    int f3_tab[8] = '{0, 1, 2, 4, 5, 2, 3, 7};

    initial begin
        total = 0;
        bad   = 0;
        m_pend = '0;
        aresetn = 1'b0;
        srst    = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_rd_addr = '0;
        bus.req_funct3  = '0;
        bus.req_offset  = '0;
        bus.rdata_valid = 1'b0;
        bus.rdata       = '0;
        bus.rresp       = '0;
        repeat (2) @(posedge aclk);
        #1;
        checkResetState("reset");
        checkOutput("reset_req_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge aclk);
        aresetn = 1'b1;

        // LB x5 off 2: sign-extended 0x80
        applyStimulus(1'b1, 5, 0, 2, 1'b0, 32'd0, 0, 1'b0);
        checkOutput("x5_pending", {31'd0, bus.pending[5]}, 32'd1);
        idleBeat(32'h0080_FF11, 0);
        checkOutput("x5_val", bus.rd_val, 32'hFFFF_FF80);

        // LHU x7 off 2, LW x8 back to back
        applyStimulus(1'b1, 7, 5, 2, 1'b0, 32'd0, 0, 1'b0);
        applyStimulus(1'b1, 8, 2, 0, 1'b0, 32'd0, 0, 1'b0);
        idleBeat(32'hBEEF_1234, 0);
        checkOutput("x7_val", bus.rd_val, 32'h0000_BEEF);
        idleBeat(32'hCAFE_F00D, 0);
        checkOutput("x8_val", bus.rd_val, 32'hCAFE_F00D);

        // Fill the queue, then a request together with a beat while full
        for (int r = 1; r <= DEPTH; r++)
            applyStimulus(1'b1, r, 2, 0, 1'b0, 32'd0, 0, 1'b0);
        applyStimulus(1'b1, 6, 2, 0, 1'b0, 32'd0, 0, 1'b0);
        applyStimulus(1'b1, 6, 2, 0, 1'b1, 32'h1111_2222, 0, 1'b0);
        applyStimulus(1'b1, 6, 2, 0, 1'b1, 32'h3333_4444, 0, 1'b0);
        drain();

        // Hazard on x3, then a load to x0
        applyStimulus(1'b1, 3, 0, 1, 1'b0, 32'd0, 0, 1'b0);
        applyStimulus(1'b1, 3, 0, 0, 1'b0, 32'd0, 0, 1'b0);
        applyStimulus(1'b1, 3, 0, 0, 1'b1, 32'h0000_7F00, 0, 1'b0);
        applyStimulus(1'b0, 0, 0, 0, 1'b1, 32'h0000_00F0, 0, 1'b0);
        applyStimulus(1'b1, 0, 0, 0, 1'b0, 32'd0, 0, 1'b0);
        idleBeat(32'h1234_5678, 0);

        // Error cases
        applyStimulus(1'b1, 10, 2, 2, 1'b0, 32'd0, 0, 1'b0);
        idleBeat(32'hDEAD_BEEF, 0);
        applyStimulus(1'b1, 9, 1, 0, 1'b0, 32'd0, 0, 1'b0);
        idleBeat(32'h0000_8001, 2);
        applyStimulus(1'b1, 11, 3, 0, 1'b0, 32'd0, 0, 1'b0);
        idleBeat(32'h5555_AAAA, 0);
        checkOutput("funct3_cause", {30'd0, bus.err_cause}, 32'd3);

        // Async reset with loads outstanding
        applyStimulus(1'b1, 12, 0, 0, 1'b0, 32'd0, 0, 1'b0);
        applyStimulus(1'b1, 13, 4, 3, 1'b0, 32'd0, 0, 1'b0);
        applyStimulus(1'b1, 14, 5, 2, 1'b0, 32'd0, 0, 1'b0);
        asyncResetPulse();
        idleBeat(32'hFFFF_FFFF, 0);
        applyStimulus(1'b1, 12, 2, 0, 1'b0, 32'd0, 0, 1'b0);
        idleBeat(32'h0BAD_F00D, 0);

        // Synchronous reset mid-stream
        applyStimulus(1'b1, 15, 1, 2, 1'b0, 32'd0, 0, 1'b0);
        applyStimulus(1'b1, 16, 0, 3, 1'b1, 32'h8000_0000, 0, 1'b1);
        applyStimulus(1'b1, 16, 0, 3, 1'b0, 32'd0, 0, 1'b0);
        idleBeat(32'h8000_0000, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 7),
                          f3_tab[$urandom_range(0, 7)], $urandom_range(0, 3),
                          1'($urandom_range(0, 1)), $urandom,
                          ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0,
                          1'($urandom_range(0, 99) == 0));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
